// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives the PC, handshakes the ROM and issues one word at a time.
// Latency: fetch is accepted on the ack cycle and issued the next cycle, so at best 2 cycles/instruction.
// Backpressure: instr_ready low holds ISSUE with stable data and no new fetch; a jump always wins and flushes.
module fetch_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] pc_out,
    output logic             pc_reset,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_in,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [15:0]      mem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [15:0]      instr_data,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    output logic             busy,
    output logic             timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          jump_ok;

    // Redirects are only honoured once the PC has been cleared and before an error latches.
    assign jump_ok     = jump && (state == S_IDLE || state == S_REQ || state == S_ISSUE);

    assign pc_reset    = (state == S_INIT);
    assign mem_req     = (state == S_REQ);
    assign mem_addr    = pc_out;
    assign instr_valid = (state == S_ISSUE);
    assign pc_inc      = (state == S_REQ) && mem_ack && !jump;
    assign pc_load     = jump_ok;
    assign pc_in       = jump_ok ? jump_addr : '0;
    assign busy        = (state == S_REQ) || (state == S_ISSUE) || (state == S_ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT;
            wait_cnt   <= '0;
            timeout    <= 1'b0;
            instr_data <= '0;
            instr_pc   <= '0;
        end else if (jump_ok) begin
            state    <= run ? S_REQ : S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_INIT: state <= S_IDLE;
                S_IDLE: begin
                    if (run) begin
                        state    <= S_REQ;
                        wait_cnt <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        instr_data <= mem_rdata;
                        instr_pc   <= pc_out;
                        state      <= S_ISSUE;
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        state   <= S_ERR;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        state    <= run ? S_REQ : S_IDLE;
                        wait_cnt <= '0;
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_fetch_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         run = 1'b0;
    logic         mem_ack = 1'b0;
    logic         instr_ready = 1'b0;
    logic         jump = 1'b0;
    logic [W-1:0] jump_addr = '0;
    logic         pc_reset, pc_inc, pc_load, mem_req, instr_valid, busy, timeout;
    logic [W-1:0] pc_out, pc_in, mem_addr, instr_pc;
    logic [15:0]  mem_rdata, instr_data;
    logic [W-1:0] pc_q = '0;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctrl #(.WIDTH(W), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .run(run), .pc_out(pc_out),
        .pc_reset(pc_reset), .pc_inc(pc_inc), .pc_load(pc_load), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
        .jump(jump), .jump_addr(jump_addr), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [W-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // External PC register and instruction ROM
    assign pc_out    = pc_q;
    assign mem_rdata = rom_word(mem_addr);
    always @(posedge clk) begin
        if (pc_reset)     pc_q <= '0;
        else if (pc_load) pc_q <= pc_in;
        else if (pc_inc)  pc_q <= pc_q + 16'd1;
    end

    task automatic do_reset(input logic r);
        @(negedge clk);
        reset = 1'b0; run = r; mem_ack = 1'b0; instr_ready = 1'b0; jump = 1'b0; jump_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; run = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; jump = 1'b1; jump_addr = 16'h00FF;
        #1;
        n_cmp++; if (pc_reset !== 1'b1) begin n_bad++; $display("FAIL rst_pc_reset got=%b exp=1", pc_reset); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
        n_cmp++; if (pc_inc !== 1'b0) begin n_bad++; $display("FAIL rst_pc_inc got=%b exp=0", pc_inc); end
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL rst_pc_load got=%b exp=0", pc_load); end
        n_cmp++; if (pc_in !== 16'h0) begin n_bad++; $display("FAIL rst_pc_in got=%h exp=0000", pc_in); end
        n_cmp++; if (instr_data !== 16'h0) begin n_bad++; $display("FAIL rst_instr_data got=%h exp=0000", instr_data); end
        n_cmp++; if (instr_pc !== 16'h0) begin n_bad++; $display("FAIL rst_instr_pc got=%h exp=0000", instr_pc); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (pc_reset !== 1'b1) begin n_bad++; $display("FAIL init_pc_reset got=%b exp=1", pc_reset); end
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL init_jump_ignored pc_load got=%b exp=0", pc_load); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL init_mem_req got=%b exp=0", mem_req); end
        jump = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (pc_reset !== 1'b0) begin n_bad++; $display("FAIL idle_pc_reset got=%b exp=0", pc_reset); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL idle_mem_req got=%b exp=0", mem_req); end
        @(negedge clk); #1;
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL first_req got=%b exp=1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL first_addr got=%h exp=0000", mem_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL req_busy got=%b exp=1", busy); end
    endtask

    task automatic test_stream();
        int n_prst, n_inc, first_req;
        int vcyc[$];
        logic [W-1:0] vpc[$];
        logic [15:0] vdat[$];
        n_prst = 0; n_inc = 0; first_req = -1;
        do_reset(1'b1);
        mem_ack = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (pc_reset) n_prst++;
            if (pc_inc) n_inc++;
            if (mem_req && first_req < 0) first_req = c;
            if (instr_valid) begin vcyc.push_back(c); vpc.push_back(instr_pc); vdat.push_back(instr_data); end
            @(negedge clk);
        end
        n_cmp++; if (n_prst != 1) begin n_bad++; $display("FAIL stream_pc_reset_cycles got=%0d exp=1", n_prst); end
        n_cmp++; if (first_req != 2) begin n_bad++; $display("FAIL stream_first_req_cycle got=%0d exp=2", first_req); end
        n_cmp++; if (vcyc.size() != 4) begin n_bad++; $display("FAIL stream_valid_count got=%0d exp=4", vcyc.size()); end
        n_cmp++; if (n_inc != vcyc.size()) begin n_bad++; $display("FAIL stream_inc_per_instr got=%0d exp=%0d", n_inc, vcyc.size()); end
        for (int k = 0; k < vcyc.size(); k++) begin
            n_cmp++; if (vpc[k] !== 16'(k)) begin n_bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k, vpc[k], 16'(k)); end
            n_cmp++; if (vdat[k] !== rom_word(16'(k))) begin n_bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", k, vdat[k], rom_word(16'(k))); end
            if (k > 0) begin
                n_cmp++; if (vcyc[k] - vcyc[k-1] != 2) begin n_bad++; $display("FAIL stream_spacing[%0d] got=%0d exp=2", k, vcyc[k] - vcyc[k-1]); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL stall_idle busy=%b req=%b exp=0/0", busy, mem_req); end
        jump = 1'b1; jump_addr = 16'hF197; run = 1'b1;
        #1;
        n_cmp++; if (pc_load !== 1'b1 || pc_in !== 16'hF197) begin n_bad++; $display("FAIL stall_idle_jump load=%b pc_in=%h exp=1/f197", pc_load, pc_in); end
        @(negedge clk);
        jump = 1'b0; mem_ack = 1'b1; instr_ready = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'hF197) begin n_bad++; $display("FAIL stall_fetch req=%b addr=%h exp=1/f197", mem_req, mem_addr); end
        n_cmp++; if (pc_inc !== 1'b1) begin n_bad++; $display("FAIL stall_fetch_inc got=%b exp=1", pc_inc); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, instr_valid); end
            n_cmp++; if (instr_data !== 16'hABCD) begin n_bad++; $display("FAIL stall_data[%0d] got=%h exp=abcd", i, instr_data); end
            n_cmp++; if (instr_pc !== 16'hF197) begin n_bad++; $display("FAIL stall_pc[%0d] got=%h exp=f197", i, instr_pc); end
            n_cmp++; if (mem_req !== 1'b0 || pc_inc !== 1'b0) begin n_bad++; $display("FAIL stall_quiet[%0d] req=%b inc=%b exp=0/0", i, mem_req, pc_inc); end
            @(negedge clk);
        end
        instr_ready = 1'b1; run = 1'b0; mem_ack = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_release_valid got=%b exp=1", instr_valid); end
        @(negedge clk);
        instr_ready = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL stall_to_idle valid=%b busy=%b req=%b exp=0/0/0", instr_valid, busy, mem_req); end
    endtask

    task automatic test_jump_ack();
        bit got;
        do_reset(1'b1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); #1; got = mem_req; end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL jump_wait_req got=0 exp=1"); end
        mem_ack = 1'b1; jump = 1'b1; jump_addr = 16'h1234;
        #1;
        n_cmp++; if (pc_load !== 1'b1 || pc_in !== 16'h1234) begin n_bad++; $display("FAIL jump_load load=%b pc_in=%h exp=1/1234", pc_load, pc_in); end
        n_cmp++; if (pc_inc !== 1'b0) begin n_bad++; $display("FAIL jump_no_inc got=%b exp=0", pc_inc); end
        @(negedge clk);
        mem_ack = 1'b0; jump = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL jump_flush valid=%b exp=0", instr_valid); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h1234) begin n_bad++; $display("FAIL jump_refetch req=%b addr=%h exp=1/1234", mem_req, mem_addr); end
        n_cmp++; if (pc_load !== 1'b0 || pc_in !== 16'h0) begin n_bad++; $display("FAIL jump_pc_in_idle load=%b pc_in=%h exp=0/0000", pc_load, pc_in); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; instr_ready = 1'b1;
        #1;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h1234) begin n_bad++; $display("FAIL jump_issue valid=%b pc=%h exp=1/1234", instr_valid, instr_pc); end
    endtask

    task automatic test_timeout();
        int nreq;
        bit got;
        do_reset(1'b1);
        nreq = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); #1;
            if (timeout) got = 1'b1;
            else if (mem_req) nreq++;
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL timeout_seen got=0 exp=1"); end
        n_cmp++; if (nreq != 15) begin n_bad++; $display("FAIL timeout_req_cycles got=%0d exp=15", nreq); end
        n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL err_quiet req=%b valid=%b exp=0/0", mem_req, instr_valid); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run = 1'($urandom); mem_ack = 1'($urandom); jump = 1'($urandom); instr_ready = 1'($urandom);
            jump_addr = 16'($urandom);
            #1;
            n_cmp++; if (timeout !== 1'b1 || mem_req !== 1'b0 || pc_load !== 1'b0 || pc_inc !== 1'b0) begin
                n_bad++; $display("FAIL err_sticky[%0d] to=%b req=%b load=%b inc=%b exp=1/0/0/0", i, timeout, mem_req, pc_load, pc_inc);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++; if (timeout !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL err_reset_clear to=%b busy=%b exp=0/0", timeout, busy); end
    endtask

    task automatic test_run_drop();
        bit got;
        int nreq;
        do_reset(1'b1);
        instr_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); #1; got = mem_req; end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL drop_wait_req got=0 exp=1"); end
        run = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL drop_req1 got=%b exp=1", mem_req); end
        @(negedge clk); #1;
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL drop_req2 got=%b exp=1", mem_req); end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        n_cmp++; if (pc_inc !== 1'b1) begin n_bad++; $display("FAIL drop_ack_inc got=%b exp=1", pc_inc); end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin n_bad++; $display("FAIL drop_issue valid=%b pc=%h exp=1/0000", instr_valid, instr_pc); end
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (mem_req) nreq++;
        end
        n_cmp++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL drop_idle busy=%b valid=%b exp=0/0", busy, instr_valid); end
        n_cmp++; if (nreq != 0) begin n_bad++; $display("FAIL drop_no_refetch got=%0d exp=0", nreq); end
    endtask

    task automatic test_reset_issue();
        bit got;
        do_reset(1'b1);
        mem_ack = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); #1; got = instr_valid; end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL rissue_wait_valid got=0 exp=1"); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc_inc !== 1'b0) begin n_bad++; $display("FAIL rissue_drop valid=%b req=%b inc=%b exp=0/0/0", instr_valid, mem_req, pc_inc); end
        n_cmp++; if (pc_reset !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL rissue_pc_reset prst=%b to=%b exp=1/0", pc_reset, timeout); end
        n_cmp++; if (instr_data !== 16'h0) begin n_bad++; $display("FAIL rissue_data got=%h exp=0000", instr_data); end
        @(negedge clk); #1;
        n_cmp++; if (pc_inc !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rissue_hold inc=%b req=%b exp=0/0", pc_inc, mem_req); end
    endtask

    // Transaction model: one outstanding fetch address, at most one pending instruction.
    task automatic test_random();
        bit got, pend;
        logic [W-1:0] model_pc, pend_pc;
        int waits, issued;
        do_reset(1'b1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); #1; got = mem_req; end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL rand_wait_req got=0 exp=1"); end
        model_pc = '0; pend_pc = '0; pend = 1'b0; waits = 0; issued = 0;
        for (int i = 0; i < 400; i++) begin
            jump        = ($urandom_range(0, 15) == 0);
            jump_addr   = 16'($urandom);
            mem_ack     = (waits >= 8) || ($urandom_range(0, 1) == 1);
            instr_ready = ($urandom_range(0, 9) < 6);
            #1;
            n_cmp++; if (pc_inc && pc_load) begin n_bad++; $display("FAIL rand_inc_load_both cyc=%0d inc=%b load=%b", i, pc_inc, pc_load); end
            n_cmp++; if (pc_load !== jump) begin n_bad++; $display("FAIL rand_pc_load cyc=%0d got=%b exp=%b", i, pc_load, jump); end
            n_cmp++; if (pc_in !== (jump ? jump_addr : 16'h0)) begin n_bad++; $display("FAIL rand_pc_in cyc=%0d got=%h exp=%h", i, pc_in, jump ? jump_addr : 16'h0); end
            n_cmp++; if (instr_valid !== pend) begin n_bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, instr_valid, pend); end
            n_cmp++; if (mem_req !== !pend) begin n_bad++; $display("FAIL rand_req cyc=%0d got=%b exp=%b", i, mem_req, !pend); end
            n_cmp++; if (pc_inc !== (!pend && mem_ack && !jump)) begin n_bad++; $display("FAIL rand_inc cyc=%0d got=%b exp=%b", i, pc_inc, !pend && mem_ack && !jump); end
            if (!pend) begin
                n_cmp++; if (mem_addr !== model_pc) begin n_bad++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, mem_addr, model_pc); end
            end else begin
                n_cmp++; if (instr_pc !== pend_pc || instr_data !== rom_word(pend_pc)) begin
                    n_bad++; $display("FAIL rand_instr cyc=%0d pc=%h data=%h exp=%h/%h", i, instr_pc, instr_data, pend_pc, rom_word(pend_pc));
                end
            end
            if (jump) begin
                pend = 1'b0; model_pc = jump_addr; waits = 0;
            end else if (!pend && mem_ack) begin
                pend = 1'b1; pend_pc = model_pc; model_pc = model_pc + 16'd1; waits = 0;
            end else if (pend && instr_ready) begin
                pend = 1'b0; issued++;
            end else if (!pend) begin
                waits++;
            end
            @(negedge clk);
        end
        jump = 1'b0;
        n_cmp++; if (issued < 30) begin n_bad++; $display("FAIL rand_issued got=%0d exp>=30", issued); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump_ack();
        test_timeout();
        test_run_drop();
        test_reset_issue();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
